// File: rtl/hci_router_order_gen.sv
// hci_router_order_gen: one-slot wide request stage feeding a reorder router, with a credit-limited read response FIFO
module hci_router_order_gen #(
    parameter int NB_IN_CHAN  = 2,
    parameter int NB_OUT_CHAN = 2,
    parameter int RESP_DEPTH  = 2,
    localparam int OW = NB_OUT_CHAN > 1 ? $clog2(NB_OUT_CHAN) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     req_i,
    output logic                     gnt_o,
    input  logic [31:0]              add_i,
    input  logic                     wen_i,
    input  logic [NB_IN_CHAN*4-1:0]  be_i,
    input  logic [NB_IN_CHAN*32-1:0] data_i,
    output logic                     r_valid_o,
    input  logic                     r_ready_i,
    output logic [NB_IN_CHAN*32-1:0] r_data_o,
    output logic                     err_o,
    output logic                     rtr_req_o,
    input  logic                     rtr_gnt_i,
    output logic [NB_IN_CHAN*32-1:0] rtr_add_o,
    output logic                     rtr_wen_o,
    output logic [NB_IN_CHAN*4-1:0]  rtr_be_o,
    output logic [NB_IN_CHAN*32-1:0] rtr_data_o,
    output logic [OW-1:0]            rtr_order_o,
    input  logic                     rtr_r_valid_i,
    input  logic [NB_IN_CHAN*32-1:0] rtr_r_data_i
);
    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = $clog2(RESP_DEPTH + 1);
    typedef enum logic {EMPTY, FULL} slot_t;
    slot_t state_q, state_d;
    logic credit_ok, hs, capture, push, pop, inflight_q;
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    logic [NB_IN_CHAN*32-1:0] mem_q [RESP_DEPTH];
    assign push = rtr_r_valid_i && inflight_q;
    assign pop = r_valid_o && r_ready_i;
    assign r_valid_o = count_q != '0;
    assign r_data_o = mem_q[rd_q];
    // slot handshakes: reads only issue when the FIFO can hold every outstanding response
    always_comb begin
        credit_ok = !rtr_wen_o || (int'(count_q) + int'(inflight_q) < RESP_DEPTH);
        rtr_req_o = state_q == FULL && credit_ok;
        hs = rtr_req_o && rtr_gnt_i;
        gnt_o = state_q == EMPTY || hs;
        capture = req_i && gnt_o;
        state_d = capture ? FULL : hs ? EMPTY : state_q;
    end
    // slot state, in-flight read marker and sticky misalignment flag
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q <= EMPTY;
            inflight_q <= 1'b0;
            err_o <= 1'b0;
        end else begin
            state_q <= state_d;
            inflight_q <= hs && rtr_wen_o;
            if (capture && add_i[1:0] != 2'b00) err_o <= 1'b1;
        end
    end
    // request payload, per-word addresses precomputed so router outputs are pure registers
    always_ff @(posedge clk_i) begin
        if (capture) begin
            rtr_wen_o <= wen_i;
            rtr_be_o <= be_i;
            rtr_data_o <= data_i;
            rtr_order_o <= NB_OUT_CHAN > 1 ? add_i[2 +: OW] : '0;
            for (int i = 0; i < NB_IN_CHAN; i++) rtr_add_o[32*i +: 32] <= add_i + 32'(4 * i);
        end
    end
    // response FIFO; router responses accepted only for an in-flight read
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= rtr_r_data_i;
                wr_q <= wr_q == PW'(RESP_DEPTH - 1) ? '0 : wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q == PW'(RESP_DEPTH - 1) ? '0 : rd_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end
    assert property (@(posedge clk_i) disable iff (rst_i || clear_i)
        !(push && !pop && int'(count_q) == RESP_DEPTH));
endmodule

// File: tb/tb_hci_router_order_gen.sv
// tb_hci_router_order_gen: directed and random checks against a transaction-level reference model
module tb_hci_router_order_gen;
    localparam int NI = 2, NO = 4, D = 2;
    logic clk_i = 1'b0, rst_i, clear_i, req_i, gnt_o, wen_i, r_valid_o, r_ready_i, err_o;
    logic rtr_req_o, rtr_gnt_i, rtr_wen_o, rtr_r_valid_i;
    logic [31:0] add_i;
    logic [NI*4-1:0] be_i, rtr_be_o;
    logic [NI*32-1:0] data_i, r_data_o, rtr_add_o, rtr_data_o, rtr_r_data_i;
    logic [1:0] rtr_order_o;
    always #5 clk_i = ~clk_i;
    hci_router_order_gen #(.NB_IN_CHAN(NI), .NB_OUT_CHAN(NO), .RESP_DEPTH(D)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .req_i(req_i), .gnt_o(gnt_o),
        .add_i(add_i), .wen_i(wen_i), .be_i(be_i), .data_i(data_i), .r_valid_o(r_valid_o),
        .r_ready_i(r_ready_i), .r_data_o(r_data_o), .err_o(err_o), .rtr_req_o(rtr_req_o),
        .rtr_gnt_i(rtr_gnt_i), .rtr_add_o(rtr_add_o), .rtr_wen_o(rtr_wen_o), .rtr_be_o(rtr_be_o),
        .rtr_data_o(rtr_data_o), .rtr_order_o(rtr_order_o), .rtr_r_valid_i(rtr_r_valid_i),
        .rtr_r_data_i(rtr_r_data_i)
    );
    int checks = 0, errors = 0, dut_rd_hs = 0;
    bit p_v, p_wen, infl, err_m, prev_hs;
    logic [31:0] p_add;
    logic [NI*4-1:0] p_be;
    logic [NI*32-1:0] p_data;
    logic [NI*32-1:0] resp_q[$];
    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic set_req(bit r, bit w, logic [31:0] a);
        req_i = r;
        wen_i = w;
        add_i = a;
        be_i = NI*4'($urandom);
        data_i = {$urandom, $urandom};
    endtask
    task automatic step();
        bit e_req, e_gnt, e_rv, hs, pop, push, cap;
        logic [NI*32-1:0] e_add;
        rtr_r_valid_i = prev_hs || ($urandom_range(7) == 0);
        rtr_r_data_i = {$urandom, $urandom};
        #1;
        e_req = p_v && (!p_wen || resp_q.size() + int'(infl) < D);
        e_gnt = !p_v || (e_req && rtr_gnt_i);
        e_rv = resp_q.size() > 0;
        chk("gnt", gnt_o, e_gnt);
        chk("rtr_req", rtr_req_o, e_req);
        chk("r_valid", r_valid_o, e_rv);
        chk("err", err_o, err_m);
        if (e_rv) chk("r_data", r_data_o, resp_q[0]);
        if (e_req) begin
            for (int i = 0; i < NI; i++) e_add[32*i +: 32] = p_add + 32'(4 * i);
            chk("rtr_add", rtr_add_o, e_add);
            chk("rtr_order", rtr_order_o, 2'((p_add / 4) % NO));
            chk("rtr_wen", rtr_wen_o, p_wen);
            chk("rtr_be", rtr_be_o, p_be);
            chk("rtr_data", rtr_data_o, p_data);
        end
        if (rtr_req_o && rtr_gnt_i && rtr_wen_o) dut_rd_hs++;
        hs = e_req && rtr_gnt_i;
        pop = e_rv && r_ready_i;
        push = infl && rtr_r_valid_i;
        cap = req_i && e_gnt;
        @(posedge clk_i);
        if (rst_i || clear_i) begin
            p_v = 0;
            infl = 0;
            err_m = 0;
            resp_q.delete();
        end else begin
            if (pop) void'(resp_q.pop_front());
            if (push) resp_q.push_back(rtr_r_data_i);
            infl = hs && p_wen;
            if (cap) begin
                p_v = 1;
                p_wen = wen_i;
                p_add = add_i;
                p_be = be_i;
                p_data = data_i;
                if (add_i[1:0] != 2'b00) err_m = 1;
            end else if (hs) p_v = 0;
        end
        prev_hs = hs;
        @(negedge clk_i);
    endtask
    task automatic drain();
        req_i = 0;
        r_ready_i = 1;
        rtr_gnt_i = 1;
        repeat (5) step();
    endtask
    initial begin
        rst_i = 1; clear_i = 0; r_ready_i = 0; rtr_gnt_i = 0;
        rtr_r_valid_i = 0; rtr_r_data_i = '0;
        set_req(0, 0, 0);
        p_v = 0; infl = 0; err_m = 0; prev_hs = 0;
        p_wen = 0; p_add = '0; p_be = '0; p_data = '0;
        repeat (2) @(negedge clk_i);
        rst_i = 0;
        chk("rst_gnt", gnt_o, 1);
        chk("rst_rvalid", r_valid_o, 0);
        chk("rst_rtr_req", rtr_req_o, 0);
        chk("rst_err", err_o, 0);
        rtr_gnt_i = 1; r_ready_i = 1;
        set_req(1, 1, 32'h1008);
        step();
        req_i = 0;
        chk("order_1008", rtr_order_o, 2);
        chk("add_1008", rtr_add_o, 64'h0000100C_00001008);
        step();
        chk("lat2_rvalid", r_valid_o, 0);
        step();
        chk("lat3_rvalid", r_valid_o, 1);
        drain();
        r_ready_i = 0;
        dut_rd_hs = 0;
        repeat (8) begin
            set_req(1, 1, 32'h4000 + 32'($urandom_range(255)) * 4);
            step();
        end
        req_i = 0;
        chk("stall_rd_hs", dut_rd_hs, 2);
        chk("stall_rtr_req", rtr_req_o, 0);
        r_ready_i = 1;
        step();
        r_ready_i = 0;
        chk("resume_rtr_req", rtr_req_o, 1);
        drain();
        r_ready_i = 0;
        set_req(1, 0, 32'h2000);
        step();
        set_req(1, 1, 32'h2010);
        step();
        req_i = 0;
        repeat (4) step();
        chk("wr_rd_valid", r_valid_o, 1);
        r_ready_i = 1;
        step();
        chk("wr_rd_single", r_valid_o, 0);
        set_req(1, 1, 32'hFFFFFFFC);
        step();
        req_i = 0;
        chk("wrap_w0", rtr_add_o[31:0], 32'hFFFFFFFC);
        chk("wrap_w1", rtr_add_o[63:32], 32'h0);
        drain();
        set_req(1, 1, 32'h1002);
        step();
        req_i = 0;
        chk("err_set", err_o, 1);
        repeat (3) step();
        chk("err_sticky", err_o, 1);
        clear_i = 1;
        step();
        clear_i = 0;
        chk("err_clear", err_o, 0);
        drain();
        set_req(1, 1, 32'h3000);
        step();
        req_i = 0;
        step();
        rst_i = 1;
        step();
        rst_i = 0;
        repeat (3) begin
            chk("rst_mid_rvalid", r_valid_o, 0);
            step();
        end
        chk("rst_mid_gnt", gnt_o, 1);
        repeat (600) begin
            set_req($urandom_range(3) != 0, $urandom_range(1),
                    {$urandom_range(65535), 14'($urandom), ($urandom_range(15) == 0) ? 2'($urandom) : 2'b00});
            r_ready_i = $urandom_range(1);
            rtr_gnt_i = $urandom_range(3) != 0;
            clear_i = $urandom_range(63) == 0;
            step();
        end
        clear_i = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
